// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and opcode helper shared by the ALU issue path
package alu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h4;
  localparam logic [3:0] OP_DIV = 4'h8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic op_legal(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// rtl/alu_issue_ctrl_if.sv - request, ALU and response signals of the issue controller
interface alu_issue_ctrl_if #(
  parameter int WIDTH = 16
);
  logic             req0_valid;
  logic             req0_ready;
  logic [3:0]       req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [3:0]       req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [3:0]       alu_con;
  logic [WIDTH-1:0] alu_in1;
  logic [WIDTH-1:0] alu_in2;
  logic [WIDTH-1:0] alu_out;
  logic [WIDTH-1:0] alu_r0;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_out;
  logic [WIDTH-1:0] rsp_r0;
  logic             rsp_r0_wr;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  alu_out, alu_r0, rsp_ready,
    output req0_ready, req1_ready, alu_con, alu_in1, alu_in2,
    output rsp_valid, rsp_id, rsp_out, rsp_r0, rsp_r0_wr, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output alu_out, alu_r0, rsp_ready,
    input  req0_ready, req1_ready, alu_con, alu_in1, alu_in2,
    input  rsp_valid, rsp_id, rsp_out, rsp_r0, rsp_r0_wr, rsp_err, busy
  );

endinterface

// File: rtl/alu_issue_ctrl_rr_arb2.sv
// rtl/alu_issue_ctrl_rr_arb2.sv - combinational two-requester round-robin arbiter
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  input  logic enable,
  output logic grant0,
  output logic grant1,
  output logic grant_id
);

  // On a tie the requester that did not win last time gets the slot.
  always_comb begin
    grant_id = (valid0 && valid1) ? ~last_grant : valid1;
    grant0   = enable && valid0 && !grant_id;
    grant1   = enable && valid1 && grant_id;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - arbitrates two requesters onto a multicycle ALU and returns tagged results
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  alu_issue_ctrl_if.slave   bus
);

  localparam int MAX_L = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW    = $clog2(MAX_L + 1);

  state_t           r_state;
  state_t           w_next;
  logic             r_last_grant;
  logic             r_id;
  logic [CW-1:0]    r_count;
  logic [3:0]       r_alu_con;
  logic [WIDTH-1:0] r_alu_in1;
  logic [WIDTH-1:0] r_alu_in2;
  logic [WIDTH-1:0] r_rsp_out;
  logic [WIDTH-1:0] r_rsp_r0;
  logic             r_rsp_r0_wr;
  logic             r_rsp_err;

  logic             w_grant0;
  logic             w_grant1;
  logic             w_grant_id;
  logic             w_hs;
  logic [3:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic             w_legal;
  logic             w_div0;
  logic [CW-1:0]    w_lat;

  rr_arb2 u_arb (
    .valid0     (bus.req0_valid),
    .valid1     (bus.req1_valid),
    .last_grant (r_last_grant),
    .enable     (r_state == IDLE),
    .grant0     (w_grant0),
    .grant1     (w_grant1),
    .grant_id   (w_grant_id)
  );

  always_comb begin
    w_hs     = w_grant0 || w_grant1;
    w_sel_op = w_grant_id ? bus.req1_op : bus.req0_op;
    w_sel_a  = w_grant_id ? bus.req1_a  : bus.req0_a;
    w_sel_b  = w_grant_id ? bus.req1_b  : bus.req0_b;
    w_legal  = op_legal(w_sel_op);
    w_div0   = (w_sel_op == OP_DIV) && (w_sel_b == '0);
    case (w_sel_op)
      OP_MUL:  w_lat = CW'(MUL_CYCLES - 1);
      OP_DIV:  w_lat = CW'(DIV_CYCLES - 1);
      default: w_lat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Rejected ops skip EXEC entirely so the ALU never sees them.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_hs) w_next = (!w_legal || w_div0) ? DONE : EXEC;
      EXEC:    if (r_count == '0) w_next = DONE;
      DONE:    if (bus.rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_count      <= '0;
      r_alu_con    <= OP_NOP;
      r_alu_in1    <= '0;
      r_alu_in2    <= '0;
      r_rsp_out    <= '0;
      r_rsp_r0     <= '0;
      r_rsp_r0_wr  <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_hs) begin
          r_last_grant <= w_grant_id;
          r_id         <= w_grant_id;
          r_rsp_r0_wr  <= 1'b0;
          if (!w_legal) begin
            r_rsp_out <= '0;
            r_rsp_r0  <= '0;
            r_rsp_err <= 1'b1;
          end else if (w_div0) begin
            r_rsp_out <= '1;
            r_rsp_r0  <= w_sel_a;
            r_rsp_err <= 1'b1;
          end else begin
            r_alu_con <= w_sel_op;
            r_alu_in1 <= w_sel_a;
            r_alu_in2 <= w_sel_b;
            r_count   <= w_lat;
            r_rsp_err <= 1'b0;
          end
        end
        EXEC: if (r_count == '0) begin
          r_rsp_out   <= bus.alu_out;
          r_rsp_r0    <= bus.alu_r0;
          r_rsp_r0_wr <= (r_alu_con == OP_MUL) || (r_alu_con == OP_DIV);
          r_alu_con   <= OP_NOP;
          r_alu_in1   <= '0;
          r_alu_in2   <= '0;
        end else begin
          r_count <= r_count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;
  assign bus.alu_con    = r_alu_con;
  assign bus.alu_in1    = r_alu_in1;
  assign bus.alu_in2    = r_alu_in2;
  assign bus.rsp_valid  = (r_state == DONE);
  assign bus.rsp_id     = r_id;
  assign bus.rsp_out    = r_rsp_out;
  assign bus.rsp_r0     = r_rsp_r0;
  assign bus.rsp_r0_wr  = r_rsp_r0_wr;
  assign bus.rsp_err    = r_rsp_err;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed scoreboard bench for alu_issue_ctrl
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.WIDTH(16)) bus ();

  alu_issue_ctrl #(.WIDTH(16), .MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Reference ALU: r0 is the product high half or the remainder, 0 otherwise.
  logic [31:0] prod;
  always_comb begin
    prod        = {16'h0, bus.alu_in1} * {16'h0, bus.alu_in2};
    bus.alu_out = 16'h0;
    bus.alu_r0  = 16'h0;
    case (bus.alu_con)
      OP_ADD: bus.alu_out = bus.alu_in1 + bus.alu_in2;
      OP_SUB: bus.alu_out = bus.alu_in1 - bus.alu_in2;
      OP_MUL: {bus.alu_r0, bus.alu_out} = prod;
      OP_DIV: if (bus.alu_in2 != 0) begin
        bus.alu_out = bus.alu_in1 / bus.alu_in2;
        bus.alu_r0  = bus.alu_in1 % bus.alu_in2;
      end
      default: ;
    endcase
  end

  typedef struct packed {
    logic        id;
    logic [15:0] out;
    logic [15:0] r0;
    logic        wr;
    logic        err;
  } rsp_t;

  rsp_t sb[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic rsp_t model(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    rsp_t r;
    logic [31:0] p;
    r = '0;
    r.id = id;
    p = {16'h0, a} * {16'h0, b};
    case (op)
      4'h1: r.out = a + b;
      4'h2: r.out = a - b;
      4'h4: begin r.out = p[15:0]; r.r0 = p[31:16]; r.wr = 1'b1; end
      4'h8: if (b == 0) begin r.err = 1'b1; r.out = 16'hFFFF; r.r0 = a; end
            else begin r.out = a / b; r.r0 = a % b; r.wr = 1'b1; end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  task automatic drive(input logic id, input logic v, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (!id) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic check_rsp(input string tag);
    rsp_t e;
    chk({tag, " sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    chk({tag, " rsp_id"},    bus.rsp_id,    e.id);
    chk({tag, " rsp_out"},   bus.rsp_out,   e.out);
    chk({tag, " rsp_r0"},    bus.rsp_r0,    e.r0);
    chk({tag, " rsp_r0_wr"}, bus.rsp_r0_wr, e.wr);
    chk({tag, " rsp_err"},   bus.rsp_err,   e.err);
  endtask

  task automatic wait_grant(input string tag, input logic id);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      #1;
      got = id ? bus.req1_ready : bus.req0_ready;
      if (!got) @(negedge clk);
    end
    chk({tag, " grant"}, got, 1);
  endtask

  // Single op from one requester; L is the expected ALU hold window (0 = ALU untouched).
  task automatic do_op(input string tag, input logic id, input logic [3:0] op,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] eo, input logic [15:0] er0,
                       input logic ewr, input logic eerr, input int L);
    rsp_t e;
    int lat, alu_cyc;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(id, 1'b1, op, a, b);
    wait_grant(tag, id);
    e.id = id; e.out = eo; e.r0 = er0; e.wr = ewr; e.err = eerr;
    sb.push_back(e);
    @(negedge clk);
    drive(id, 1'b0, 4'h0, 16'h0, 16'h0);
    lat = 0;
    alu_cyc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (bus.alu_con != 0) begin
        alu_cyc++;
        if (alu_cyc == 1) begin
          chk({tag, " alu_con"}, bus.alu_con, op);
          chk({tag, " alu_in1"}, bus.alu_in1, a);
          chk({tag, " alu_in2"}, bus.alu_in2, b);
        end
      end
      if (bus.rsp_valid) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, L + 1);
    chk({tag, " alu_cycles"}, alu_cyc, L);
    check_rsp(tag);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, " rsp_valid_drop"}, bus.rsp_valid, 0);
    chk({tag, " busy_idle"}, bus.busy, 0);
  endtask

  initial begin
    rsp_t e;
    int ngr, lat;
    logic seen;

    rst = 1'b1;
    bus.rsp_ready = 1'b0;
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
    #1;
    chk("reset alu_con",   bus.alu_con,   0);
    chk("reset alu_in1",   bus.alu_in1,   0);
    chk("reset rsp_valid", bus.rsp_valid, 0);
    chk("reset busy",      bus.busy,      0);
    chk("reset rsp_out",   bus.rsp_out,   0);
    chk("reset rsp_err",   bus.rsp_err,   0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Both requesters held valid: req0 wins first after reset, then strict alternation.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_ADD, 16'h0010, 16'h0020);
    drive(1'b1, 1'b1, 4'h3,   16'h1111, 16'h2222);
    bus.rsp_ready = 1'b1;
    ngr = 0;
    for (int cyc = 0; cyc < 60 && (ngr < 4 || sb.size() > 0); cyc++) begin
      #1;
      if (bus.rsp_valid) check_rsp("arb");
      if (ngr < 4 && (bus.req0_ready || bus.req1_ready)) begin
        chk("arb one_ready", bus.req0_ready & bus.req1_ready, 0);
        chk("arb order", bus.req1_ready, ngr % 2);
        if (bus.req1_ready) sb.push_back(model(1'b1, 4'h3, 16'h1111, 16'h2222));
        else                sb.push_back(model(1'b0, OP_ADD, 16'h0010, 16'h0020));
        ngr++;
      end
      @(negedge clk);
      if (ngr == 4) begin
        drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
      end
    end
    chk("arb grants", ngr, 4);
    chk("arb drained", sb.size(), 0);
    bus.rsp_ready = 1'b0;

    do_op("add",  1'b0, OP_ADD, 16'h0003, 16'h0004, 16'h0007, 16'h0000, 1'b0, 1'b0, 1);
    do_op("mul",  1'b1, OP_MUL, 16'h1234, 16'h0100, 16'h3400, 16'h0012, 1'b1, 1'b0, 2);
    do_op("div",  1'b0, OP_DIV, 16'h0007, 16'h0002, 16'h0003, 16'h0001, 1'b1, 1'b0, 4);
    do_op("div0", 1'b0, OP_DIV, 16'h0009, 16'h0000, 16'hFFFF, 16'h0009, 1'b0, 1'b1, 0);

    // Backpressure: last grant was req0, so req1 wins the tie; req0 waits through DONE.
    @(negedge clk);
    drive(1'b1, 1'b1, OP_MUL, 16'h0003, 16'h0005);
    drive(1'b0, 1'b1, OP_ADD, 16'h0100, 16'h0001);
    wait_grant("bp mul", 1'b1);
    e = model(1'b1, OP_MUL, 16'h0003, 16'h0005);
    sb.push_back(e);
    @(negedge clk);
    drive(1'b1, 1'b0, 4'h0, 16'h0, 16'h0);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (bus.rsp_valid) lat = k;
      else @(negedge clk);
    end
    chk("bp latency", lat, 3);
    for (int j = 0; j < 3; j++) begin
      chk("bp hold valid",  bus.rsp_valid,  1);
      chk("bp hold out",    bus.rsp_out,    e.out);
      chk("bp hold r0",     bus.rsp_r0,     e.r0);
      chk("bp hold id",     bus.rsp_id,     e.id);
      chk("bp hold wr",     bus.rsp_r0_wr,  e.wr);
      chk("bp req0_ready",  bus.req0_ready, 0);
      chk("bp req1_ready",  bus.req1_ready, 0);
      @(negedge clk);
    end
    check_rsp("bp mul");
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    #1;
    chk("bp rsp_valid_drop", bus.rsp_valid, 0);
    chk("bp next grant", bus.req0_ready, 1);
    sb.push_back(model(1'b0, OP_ADD, 16'h0100, 16'h0001));
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (bus.rsp_valid) lat = k;
      else @(negedge clk);
    end
    chk("bp add latency", lat, 2);
    check_rsp("bp add");
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;

    // Reset in the second EXEC cycle of a divide abandons it without a response.
    @(negedge clk);
    drive(1'b0, 1'b1, OP_DIV, 16'h0007, 16'h0002);
    wait_grant("rstdiv", 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    @(negedge clk);
    chk("rstdiv alu_con pre", bus.alu_con, OP_DIV);
    #1 rst = 1'b1;
    #1;
    chk("rstdiv alu_con", bus.alu_con, 0);
    chk("rstdiv busy", bus.busy, 0);
    chk("rstdiv rsp_valid", bus.rsp_valid, 0);
    #1 rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    chk("rstdiv no_rsp", seen, 0);

    do_op("sub", 1'b0, OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1);
    chk("end sb_empty", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequencing controller that sits in front of the shared 16-bit combinational ALU (add/sub/mul/div, with r0 as the upper/remainder result).
- Accepts operation requests from two requesters (req0, req1) using valid/ready handshakes, arbitrates between them round-robin, and drives the ALU opcode and operands.
- Holds those ALU inputs stable for a per-operation multicycle window, because the mul/div paths are multicycle.
- Captures the result and returns it, tagged with the requester ID, on a valid/ready response port.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- MUL_CYCLES, 2, cycles the ALU inputs are held for multiply (>=1).
- DIV_CYCLES, 4, cycles the ALU inputs are held for divide (>=1).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0_valid  in  1  requester 0 has an op
- req0_ready  out  1  requester 0 op accepted this cycle
- req0_op  in  4  opcode: 1 add, 2 sub, 4 mul, 8 div
- req0_a, req0_b  in  WIDTH  operands in1, in2
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as req0, for requester 1
- alu_con  out  4  opcode to the ALU; 0 when idle
- alu_in1, alu_in2  out  WIDTH  operands to the ALU
- alu_out  in  WIDTH  ALU low result / quotient
- alu_r0  in  WIDTH  ALU high product / remainder
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_id  out  1  requester that issued the op
- rsp_out  out  WIDTH  result
- rsp_r0  out  WIDTH  high/remainder result
- rsp_r0_wr  out  1  1 for mul/div (r0 must be written), else 0
- rsp_err  out  1  illegal opcode or divide by zero
- busy  out  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: all outputs 0; state IDLE; last_grant=1, so req0 wins the first tie. Assertion of rst mid-operation abandons the in-flight op with no response, and alu_con goes to 0 immediately.
- States: IDLE, EXEC, DONE.
- IDLE, arbitration:
  - If exactly one reqN_valid is high, grant N.
  - If both are high, grant the requester that is not last_grant.
  - reqN_ready is combinational and asserted only in IDLE, for the granted N. Handshake = valid & ready.
  - On handshake: latch op, a, b and id; update last_grant.
- IDLE, opcode checks on handshake:
  - Legal op, b!=0 or op!=div: load count L-1 and go to EXEC. L=1 for add/sub, MUL_CYCLES for mul, DIV_CYCLES for div.
  - Op not in {1,2,4,8}: go directly to DONE with rsp_err=1, rsp_out=0, rsp_r0=0, rsp_r0_wr=0. The ALU is not driven.
  - Div with b==0: go directly to DONE with rsp_err=1, rsp_out={WIDTH{1}}, rsp_r0=a, rsp_r0_wr=0. The ALU is not driven.
- EXEC:
  - alu_con, alu_in1 and alu_in2 are registered, held constant for exactly L cycles, and 0 in every other state.
  - Count down each cycle. On the last cycle (count==0), capture alu_out and alu_r0 into rsp_out/rsp_r0 and go to DONE.
  - rsp_r0_wr = (op==mul or op==div). For add/sub, rsp_r0 is captured but ignored.
- DONE:
  - rsp_valid=1; all rsp_* fields stable.
  - rsp_valid & rsp_ready: rsp_valid drops next cycle and the state returns to IDLE.
  - No new request is accepted before the IDLE cycle, so back-to-back throughput is one op per L+2 cycles.
- Latency: handshake at edge N → alu_con valid during cycles N+1..N+L → rsp_valid from cycle N+L+1. Error ops: rsp_valid from N+1.
- Arithmetic wraps modulo 2^WIDTH exactly as the ALU produces it; the controller performs no arithmetic except the b==0 compare.
- Simultaneous events: requests arriving while busy wait with valid held; they are not dropped. A requester deasserting valid before grant is legal.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_NOP=4'h0, OP_ADD=4'h1, OP_SUB=4'h2, OP_MUL=4'h4, OP_DIV=4'h8.
  - State encoding IDLE/EXEC/DONE.
  - The ALU also imports alu_pkg.
- Sub-module rr_arb2: two-requester round-robin arbiter.
  - Inputs: valid0, valid1, last_grant, enable.
  - Outputs: grant0, grant1, grant_id.
  - Purely combinational; the last_grant register lives in the parent.

Test Plan:
- Add: req0 op=1 a=0x0003 b=0x0004, handshake at N → alu_con=1 at N+1 only; rsp_valid at N+2 with rsp_out=0x0007, rsp_id=0, rsp_r0_wr=0, rsp_err=0.
- Mul: req1 op=4 a=0x1234 b=0x0100, MUL_CYCLES=2 → alu_con=4 for 2 cycles; rsp_out=0x3400, rsp_r0=0x0012, rsp_r0_wr=1, rsp_id=1, rsp_valid at N+3.
- Divide: req0 op=8 a=0x0007 b=0x0002 → rsp_out=0x0003, rsp_r0=0x0001 at N+5. Divide by zero: a=0x0009 b=0 → rsp_valid at N+1, rsp_err=1, rsp_out=0xFFFF, rsp_r0=0x0009, and alu_con stays 0.
- Arbitration: req0 and req1 valid continuously after reset → grant order 0,1,0,1; the non-granted ready stays 0; an illegal op=4'h3 on req1 → rsp_err=1, rsp_out=0.
- Backpressure: rsp_ready low for 3 cycles in DONE → all rsp_* held, req*_ready=0; the 4th cycle accepts, and IDLE grants the next request the following cycle.
- Reset mid-divide: rst pulsed during EXEC cycle 2 → alu_con=0 and busy=0 asynchronously, no rsp_valid; sub 0x0000-0x0001 afterwards → rsp_out=0xFFFF.
